wb_wport_arbiter: RTL and testbench
===================================

Name: wb_wport_arbiter

Overview:
- Shares the single register-file write port between the in-order writeback bus and a long-latency unit (multiplier/divider/CSR), whose results arrive out of band.
- Pipeline writeback always has priority. Long-unit results queue in a small FIFO and drain into idle writeback slots.
- A starvation counter raises a pipeline stall so the queue is guaranteed to drain.
- Sits between the WB stage output bus and the register file.

Parameters:
- DEPTH, 4, long-unit result FIFO entries; power of 2, minimum 2.
- STARVE_LIMIT, 8, cycles the FIFO may stay non-empty without draining before stall_req asserts; minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- wb_bus  in  38  {rd[4:0], wen, data[31:0]} from the WB stage, packed MSB-first in that order.
- lu_valid  in  1  long-unit result valid.
- lu_ready  out  1  FIFO can accept a result.
- lu_rd  in  5  long-unit destination register.
- lu_data  in  32  long-unit result.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- stall_req  out  1  request to freeze the pipeline, so that wb_bus.wen stays 0 while asserted.
- lu_pending  out  1  FIFO holds at least one live (not killed) entry.

Behaviour:
- Reset (async, rst=1): FIFO empty; all kill bits clear; starvation counter 0; rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, lu_pending=0.
- lu_ready output: lu_ready = (count != DEPTH), combinational. Push occurs when lu_valid && lu_ready. A push with lu_rd=0 is accepted and its kill bit is set at entry.
- Writeback slot: "busy" when wb_bus.wen=1 and wb_bus.rd != 0; otherwise "idle".
- Port selection, registered, one cycle latency:
  - Busy slot: next rf_we=1, rf_waddr=wb rd, rf_wdata=wb data. The FIFO does not pop.
  - Idle slot, FIFO non-empty: pop the head. If the head is live, next rf_we=1 with the head's rd/data. If the head is killed, next rf_we=0.
  - Idle slot, FIFO empty: next rf_we=0. rf_waddr and rf_wdata hold their previous values.
- WAW kill: each cycle with a busy slot, every live FIFO entry whose rd equals wb rd gets its kill bit set. The younger pipeline write wins.
  - A same-cycle push whose lu_rd matches the busy wb rd is not killed. The long-unit result is treated as younger.
- Simultaneous push and pop: both proceed; count is unchanged. When full, a pop frees the slot only on the next cycle, because lu_ready does not look ahead.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs. Resets to 0 on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - stall_req is registered and equals (counter == STARVE_LIMIT).
  - stall_req holds until the FIFO is empty, then deasserts on the following cycle.
- lu_pending: combinational OR over the valid-and-not-killed entries.
- Reset mid-operation: all queued results are discarded, with no write. The block asserts no interaction with the long unit's own reset.

Optional Feature:
- Macro: WPARB_BYPASS_EN.
- Defined: when the slot is idle, the FIFO is empty, and lu_valid=1 with lu_rd != 0, the result bypasses the FIFO. Next rf_we=1 with lu_rd/lu_data. No entry is allocated. lu_ready stays 1.
- Undefined: every long-unit result goes through the FIFO. Minimum push-to-rf_we latency is 2 cycles.

Test Plan:
- Pipeline-only write: wb_bus={rd=5, wen=1, data=0xDEADBEEF} for 1 cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. With rd=0 -> rf_we=0.
- Idle drain: push lu_rd=3, data=0x11 while wen=0 -> rf_we=1, waddr=3, wdata=0x11 two cycles after the push (bypass undefined) or one cycle after (bypass defined). lu_pending then falls to 0.
- Full FIFO: 4 pushes under continuous busy wb writes to rd=1 -> lu_ready=0 after the 4th push. A 5th lu_valid is not accepted, and no rf write uses lu data.
- WAW kill: queue lu_rd=7, data=0xAA, then busy wb write rd=7, data=0xBB, then idle -> rf gets 7←0xBB once. The queued entry pops with rf_we=0 and lu_pending=0.
- Starvation (STARVE_LIMIT=8): 1 queued entry plus continuous busy wb -> stall_req=1 on the 9th cycle. Then drop wen -> entry written. stall_req=0 one cycle after the FIFO empties.
- Async reset mid-queue: 3 entries queued, rst pulsed -> all outputs 0 immediately. After release, no write of the stale entries and lu_ready=1.

Source files
------------

// File: rtl/wb_wport_arbiter.sv
// wb_wport_arbiter: shares the register-file write port between the WB bus and a queued long-unit result stream
// Optional feature macro: WPARB_BYPASS_EN lets a long-unit result skip the empty FIFO on an idle slot.
module wb_wport_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [37:0] wb_bus,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_req,
    output logic        lu_pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       wb_rd;
    logic             wb_wen;
    logic [31:0]      wb_data;
    logic             busy, empty, pop, push, bypass, head_live;
    logic [DEPTH-1:0] valid;

    logic [4:0]       mem_rd_q   [DEPTH];
    logic [4:0]       mem_rd_d   [DEPTH];
    logic [31:0]      mem_data_q [DEPTH];
    logic [31:0]      mem_data_d [DEPTH];
    logic [DEPTH-1:0] kill_q, kill_d;
    logic [AW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             stall_q, stall_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;

    assign wb_rd     = wb_bus[37:33];
    assign wb_wen    = wb_bus[32];
    assign wb_data   = wb_bus[31:0];
    assign busy      = wb_wen && (wb_rd != 5'd0);
    assign empty     = (count_q == '0);
    assign pop       = !busy && !empty;
    assign head_live = !kill_q[rptr_q];
    assign lu_ready  = (count_q != CW'(DEPTH));
`ifdef WPARB_BYPASS_EN
    assign bypass    = !busy && empty && lu_valid && (lu_rd != 5'd0);
`else
    assign bypass    = 1'b0;
`endif
    assign push      = lu_valid && lu_ready && !bypass;

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign stall_req  = stall_q;
    assign lu_pending = |(valid & ~kill_q);

    // Occupancy mask: slot i is live when its distance from the read pointer is below count
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = CW'(AW'(i) - rptr_q) < count_q;
        end
    end

    // FIFO bookkeeping: pushes, pops, and WAW kills by younger pipeline writes
    always_comb begin
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        kill_d     = kill_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy && valid[i] && (mem_rd_q[i] == wb_rd)) kill_d[i] = 1'b1;
        end
        if (push) begin
            mem_rd_d[wptr_q]   = lu_rd;
            mem_data_d[wptr_q] = lu_data;
            kill_d[wptr_q]     = (lu_rd == 5'd0);
        end
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Write-port selection and starvation tracking
    always_comb begin
        rf_we_d    = busy || (pop && head_live) || bypass;
        rf_waddr_d = busy ? wb_rd : (pop && head_live) ? mem_rd_q[rptr_q] : bypass ? lu_rd : rf_waddr_q;
        rf_wdata_d = busy ? wb_data : (pop && head_live) ? mem_data_q[rptr_q] : bypass ? lu_data : rf_wdata_q;
        starve_d   = (empty || pop) ? '0 : (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
        stall_d    = (starve_q == SW'(STARVE_LIMIT)) || (stall_q && !empty);
    end

    // Result storage needs no reset: entries are only read while marked valid
    always_ff @(posedge clk) begin
        mem_rd_q   <= mem_rd_d;
        mem_data_q <= mem_data_d;
    end

    // Control state and registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kill_q     <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            kill_q     <= kill_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end
endmodule

// File: tb/tb_wb_wport_arbiter.sv
// tb_wb_wport_arbiter: directed bench for the writeback/long-unit write-port arbiter
module tb_wb_wport_arbiter;
    logic        clk;
    logic        rst;
    logic [37:0] wb_bus;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic        lu_pending;
    int          n_vec;
    int          n_err;

    wb_wport_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .wb_bus(wb_bus), .lu_valid(lu_valid), .lu_ready(lu_ready),
        .lu_rd(lu_rd), .lu_data(lu_data), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_req(stall_req), .lu_pending(lu_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; wb_bus = '0; lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
        tick; tick;
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata, stall_req, lu_pending, lu_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL reset_state got %b/%h/%h/%b/%b/%b", rf_we, rf_waddr, rf_wdata, stall_req, lu_pending, lu_ready);
        end
        #2 rst = 1'b0;
        tick;
    endtask

    task automatic test_pipeline;
        wb_bus = {5'd5, 1'b1, 32'hDEADBEEF};
        tick;
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL pipe_write got %b %h %h exp 1 05 deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        wb_bus = {5'd0, 1'b1, 32'h12345678};
        tick;
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL pipe_rd0 got %b %h %h exp 0 05 deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        wb_bus = '0;
        tick;
        n_vec++;
        if (rf_we !== 1'b0) begin
            n_err++; $display("FAIL pipe_idle got %b exp 0", rf_we);
        end
    endtask

    task automatic test_drain;
        lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h11;
        tick;
        lu_valid = 1'b0;
`ifndef WPARB_BYPASS_EN
        n_vec++;
        if ({rf_we, lu_pending} !== 2'b01) begin
            n_err++; $display("FAIL drain_queued got we=%b pend=%b exp 0 1", rf_we, lu_pending);
        end
        tick;
`endif
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata, lu_pending} !== {1'b1, 5'd3, 32'h11, 1'b0}) begin
            n_err++; $display("FAIL drain_write got %b %h %h pend=%b exp 1 03 00000011 0", rf_we, rf_waddr, rf_wdata, lu_pending);
        end
        tick;
        n_vec++;
        if (rf_we !== 1'b0) begin
            n_err++; $display("FAIL drain_after got %b exp 0", rf_we);
        end
    endtask

    task automatic test_full;
        wb_bus = {5'd1, 1'b1, 32'h100};
        for (int i = 0; i < 4; i++) begin
            lu_valid = 1'b1; lu_rd = 5'(10 + i); lu_data = 32'hA0 + 32'(i);
            tick;
            n_vec++;
            if ({lu_ready, rf_we, rf_waddr, rf_wdata} !== {(i != 3), 1'b1, 5'd1, 32'h100}) begin
                n_err++; $display("FAIL full_push%0d got rdy=%b %b %h %h", i, lu_ready, rf_we, rf_waddr, rf_wdata);
            end
        end
        lu_rd = 5'd14; lu_data = 32'hEE;
        tick;
        n_vec++;
        if ({lu_ready, lu_pending, rf_waddr} !== {1'b0, 1'b1, 5'd1}) begin
            n_err++; $display("FAIL full_reject got rdy=%b pend=%b addr=%h exp 0 1 01", lu_ready, lu_pending, rf_waddr);
        end
        lu_valid = 1'b0; wb_bus = '0;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_vec++;
            if ({rf_we, rf_waddr, rf_wdata, lu_ready} !== {1'b1, 5'(10 + i), 32'hA0 + 32'(i), 1'b1}) begin
                n_err++; $display("FAIL full_drain%0d got %b %h %h rdy=%b", i, rf_we, rf_waddr, rf_wdata, lu_ready);
            end
        end
        tick;
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata, lu_pending} !== {1'b0, 5'd13, 32'hA3, 1'b0}) begin
            n_err++; $display("FAIL full_empty got %b %h %h pend=%b exp 0 0d 000000a3 0", rf_we, rf_waddr, rf_wdata, lu_pending);
        end
    endtask

    task automatic test_waw;
        wb_bus = {5'd2, 1'b1, 32'h22}; lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'hAA;
        tick;
        lu_valid = 1'b0;
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata, lu_pending} !== {1'b1, 5'd2, 32'h22, 1'b1}) begin
            n_err++; $display("FAIL waw_queue got %b %h %h pend=%b", rf_we, rf_waddr, rf_wdata, lu_pending);
        end
        wb_bus = {5'd7, 1'b1, 32'hBB};
        tick;
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata, lu_pending} !== {1'b1, 5'd7, 32'hBB, 1'b0}) begin
            n_err++; $display("FAIL waw_kill got %b %h %h pend=%b exp 1 07 000000bb 0", rf_we, rf_waddr, rf_wdata, lu_pending);
        end
        wb_bus = '0;
        tick;
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata, lu_pending} !== {1'b0, 5'd7, 32'hBB, 1'b0}) begin
            n_err++; $display("FAIL waw_pop_killed got %b %h %h pend=%b exp 0 07 000000bb 0", rf_we, rf_waddr, rf_wdata, lu_pending);
        end
        wb_bus = {5'd9, 1'b1, 32'h99}; lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h55;
        tick;
        lu_valid = 1'b0; wb_bus = '0;
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata, lu_pending} !== {1'b1, 5'd9, 32'h99, 1'b1}) begin
            n_err++; $display("FAIL waw_same_cycle got %b %h %h pend=%b", rf_we, rf_waddr, rf_wdata, lu_pending);
        end
        tick;
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h55}) begin
            n_err++; $display("FAIL waw_younger_lu got %b %h %h exp 1 09 00000055", rf_we, rf_waddr, rf_wdata);
        end
        wb_bus = {5'd2, 1'b1, 32'h22}; lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h77;
        tick;
        lu_valid = 1'b0; wb_bus = '0;
        n_vec++;
        if ({lu_pending, lu_ready} !== 2'b01) begin
            n_err++; $display("FAIL zero_rd_push got pend=%b rdy=%b exp 0 1", lu_pending, lu_ready);
        end
        tick;
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd2, 32'h22}) begin
            n_err++; $display("FAIL zero_rd_pop got %b %h %h exp 0 02 00000022", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_starve;
        wb_bus = {5'd1, 1'b1, 32'h1}; lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'h44;
        tick;
        lu_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick;
            n_vec++;
            if (stall_req !== (k >= 9)) begin
                n_err++; $display("FAIL starve_cycle%0d got %b exp %b", k, stall_req, (k >= 9));
            end
        end
        wb_bus = '0;
        tick;
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata, stall_req, lu_pending} !== {1'b1, 5'd4, 32'h44, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL starve_drain got %b %h %h stall=%b pend=%b", rf_we, rf_waddr, rf_wdata, stall_req, lu_pending);
        end
        tick;
        n_vec++;
        if ({stall_req, rf_we} !== 2'b00) begin
            n_err++; $display("FAIL starve_release got stall=%b we=%b exp 0 0", stall_req, rf_we);
        end
    endtask

    task automatic test_reset_mid;
        wb_bus = {5'd1, 1'b1, 32'h1};
        for (int i = 0; i < 3; i++) begin
            lu_valid = 1'b1; lu_rd = 5'(20 + i); lu_data = 32'hC0 + 32'(i);
            tick;
        end
        lu_valid = 1'b0;
        n_vec++;
        if ({lu_pending, rf_we} !== 2'b11) begin
            n_err++; $display("FAIL mid_queued got pend=%b we=%b exp 1 1", lu_pending, rf_we);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({rf_we, rf_waddr, rf_wdata, stall_req, lu_pending, lu_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL mid_async_reset got %b/%h/%h/%b/%b/%b", rf_we, rf_waddr, rf_wdata, stall_req, lu_pending, lu_ready);
        end
        #1 rst = 1'b0; wb_bus = '0;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_vec++;
            if ({rf_we, lu_pending, lu_ready} !== 3'b001) begin
                n_err++; $display("FAIL mid_after%0d got we=%b pend=%b rdy=%b exp 0 0 1", i, rf_we, lu_pending, lu_ready);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset;
        test_pipeline;
        test_drain;
        test_full;
        test_waw;
        test_starve;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
